// File: rtl/cei_mochila_periph_bridge.sv
// Peripheral bridge: decodes one system-bus access onto a one-hot target port.
// Optional access timeout is enabled by defining CEI_MOCHILA_PERIPH_TIMEOUT_EN.
package cei_mochila_periph_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;

  localparam addr_rule_t BOOTROM_RULE = '{
    idx:        32'd0,
    start_addr: 32'hF001_0000,
    end_addr:   32'hF002_0000
  };

  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

endpackage

module cei_mochila_periph_bridge
  import cei_mochila_periph_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = 1,
  parameter addr_rule_t [NUM_PERIPH-1:0] ADDR_RULES =
    {NUM_PERIPH{BOOTROM_RULE}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [31:0]              addr_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic [NUM_PERIPH-1:0]    periph_req_o,
  output logic [31:0]              periph_addr_o,
  output logic                     periph_we_o,
  output logic [3:0]               periph_be_o,
  output logic [31:0]              periph_wdata_o,
  input  logic [NUM_PERIPH*32-1:0] periph_rdata_i,
  input  logic [NUM_PERIPH-1:0]    periph_ready_i,
  output logic                     err_o
);

  localparam int IW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   sel_q;
  logic [IW-1:0]   dec_sel;
  logic            dec_hit;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            timeout;
  logic [31:0]     rdata_q;
  logic            err_q;

  assign gnt_o    = req_i & (state_q == IDLE) & rst_ni;
  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rvalid_o ? rdata_q : 32'h0;
  assign err_o    = rvalid_o & err_q;

  // Address decode; walking down makes the lowest matching rule win.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
      if (addr_i >= ADDR_RULES[i].start_addr &&
          addr_i <  ADDR_RULES[i].end_addr) begin
        dec_hit = 1'b1;
        dec_sel = ADDR_RULES[i].idx[IW-1:0];
      end
    end
  end

  // Steer request out to, and ready/data in from, the selected target only.
  always_comb begin
    sel_ready    = 1'b0;
    sel_rdata    = 32'h0;
    periph_req_o = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (sel_q == IW'(i)) begin
        sel_ready       = periph_ready_i[i];
        sel_rdata       = periph_rdata_i[32*i +: 32];
        periph_req_o[i] = (state_q == ACCESS);
      end
    end
  end

`ifdef CEI_MOCHILA_PERIPH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Count ACCESS cycles; zeroed as the access is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (gnt_o) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout = (state_q == ACCESS) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; ready wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_o) begin
          state_d = dec_hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (sel_ready || timeout) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the accepted transaction and its eventual response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      periph_addr_o  <= 32'h0;
      periph_we_o    <= 1'b0;
      periph_be_o    <= 4'h0;
      periph_wdata_o <= 32'h0;
      sel_q          <= '0;
      rdata_q        <= 32'h0;
      err_q          <= 1'b0;
    end else if (gnt_o) begin
      periph_addr_o  <= addr_i;
      periph_we_o    <= we_i;
      periph_be_o    <= be_i;
      periph_wdata_o <= wdata_i;
      sel_q          <= dec_sel;
      rdata_q        <= dec_hit ? 32'h0 : ERR_RDATA;
      err_q          <= ~dec_hit;
    end else if (state_q == ACCESS) begin
      if (sel_ready) begin
        rdata_q <= periph_we_o ? 32'h0 : sel_rdata;
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= ERR_RDATA;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cei_mochila_periph_bridge.sv
// Bench for cei_mochila_periph_bridge: transaction model plus directed cases.
// Timeout cases run only when CEI_MOCHILA_PERIPH_TIMEOUT_EN is defined.
module tb_cei_mochila_periph_bridge;
  import cei_mochila_periph_pkg::*;

  localparam int NP = 2;
  localparam int TO = 8;
  localparam logic [31:0] BAD = 32'hBADACCE5;
  localparam addr_rule_t R0 = '{idx: 32'd0,
    start_addr: 32'hF0010000, end_addr: 32'hF0020000};
  localparam addr_rule_t R1 = '{idx: 32'd1,
    start_addr: 32'hF0018000, end_addr: 32'hF0030000};
  localparam addr_rule_t [NP-1:0] RULES = {R1, R0};

  logic clk;
  logic rst_n;
  logic req;
  logic gnt;
  logic [31:0] addr;
  logic we;
  logic [3:0] be;
  logic [31:0] wdata;
  logic rvalid;
  logic [31:0] rdata;
  logic [NP-1:0] preq;
  logic [31:0] paddr;
  logic pwe;
  logic [3:0] pbe;
  logic [31:0] pwdata;
  logic [NP*32-1:0] prdata;
  logic [NP-1:0] pready;
  logic err;

  logic [31:0] tdata [NP];
  int dly [NP];
  int rcnt [NP];
  logic [NP-1:0] junk;
  logic [NP-1:0] auto_rdy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  assign prdata = {tdata[1], tdata[0]};

  cei_mochila_periph_bridge #(
    .NUM_PERIPH(NP),
    .ADDR_RULES(RULES),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .gnt_o(gnt),
    .addr_i(addr),
    .we_i(we),
    .be_i(be),
    .wdata_i(wdata),
    .rvalid_o(rvalid),
    .rdata_o(rdata),
    .periph_req_o(preq),
    .periph_addr_o(paddr),
    .periph_we_o(pwe),
    .periph_be_o(pbe),
    .periph_wdata_o(pwdata),
    .periph_rdata_i(prdata),
    .periph_ready_i(pready),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (a >= RULES[i].start_addr && a < RULES[i].end_addr)
        return int'(RULES[i].idx);
    return -1;
  endfunction

  // Target responder: ready after dly[i] extra cycles of request.
  initial begin
    pready = '0;
    auto_rdy = '0;
    for (int i = 0; i < NP; i++) rcnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NP; i++) begin
        if (preq[i]) rcnt[i]++;
        else rcnt[i] = 0;
        auto_rdy[i] = preq[i] && (rcnt[i] > dly[i]);
      end
      pready = auto_rdy | junk;
    end
  end

  // Transaction-level model and per-cycle compare.
  bit m_busy;
  int m_resp_at;
  bit m_hit;
  int m_tgt;
  bit m_we;
  int m_acc0;
  bit m_err;
  logic [31:0] m_data;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic m_pwe;
  logic [3:0] m_pbe;
  logic e_gnt;
  logic e_rv;
  logic [NP-1:0] e_preq;
  int t;

  initial begin
    m_busy = 0;
    m_resp_at = -1;
    m_hit = 0; m_tgt = 0; m_we = 0; m_acc0 = 0;
    m_err = 0; m_data = 0;
    m_paddr = 0; m_pwdata = 0; m_pwe = 0; m_pbe = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0;
        m_resp_at = -1;
        m_paddr = 0; m_pwdata = 0; m_pwe = 0; m_pbe = 0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_preq", 32'(preq), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_paddr", paddr, 0);
      end else begin
        e_gnt = req && !m_busy;
        e_rv = m_busy && (m_resp_at == cyc);
        e_preq = '0;
        if (m_busy && m_hit && m_resp_at < 0) e_preq[m_tgt] = 1'b1;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rvalid", 32'(rvalid), 32'(e_rv));
        chk("rdata", rdata, e_rv ? m_data : 32'h0);
        chk("err", 32'(err), 32'(e_rv && m_err));
        chk("preq", 32'(preq), 32'(e_preq));
        chk("paddr", paddr, m_paddr);
        chk("pwdata", pwdata, m_pwdata);
        chk("pwe_pbe", {27'h0, pwe, pbe}, {27'h0, m_pwe, m_pbe});
        if (m_busy) begin
          if (m_resp_at == cyc) begin
            m_busy = 0;
          end else if (m_resp_at < 0) begin
            if (pready[m_tgt]) begin
              m_data = m_we ? 32'h0 : tdata[m_tgt];
              m_err = 0;
              m_resp_at = cyc + 1;
            end
`ifdef CEI_MOCHILA_PERIPH_TIMEOUT_EN
            else if (cyc - m_acc0 + 1 >= TO) begin
              m_data = BAD;
              m_err = 1;
              m_resp_at = cyc + 1;
            end
`endif
          end
        end
        if (e_gnt) begin
          m_busy = 1;
          m_paddr = addr; m_pwdata = wdata;
          m_pwe = we; m_pbe = be; m_we = we;
          t = decode(addr);
          if (t >= 0) begin
            m_hit = 1; m_tgt = t;
            m_resp_at = -1;
            m_acc0 = cyc + 1;
          end else begin
            m_hit = 0;
            m_resp_at = cyc + 1;
            m_data = BAD;
            m_err = 1;
          end
        end
      end
    end
  end

  task automatic wait_gnt(output int tc);
    int n = 0;
    @(negedge clk);
    while (!gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!gnt) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout: got 0 want 1");
    end
    tc = cyc;
  endtask

  task automatic wait_rv(input int t0, output int lat,
                         output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL rvalid_timeout: got 0 want 1");
      lat = -1;
    end else begin
      lat = cyc - t0;
    end
    rd = rdata;
    er = err;
  endtask

  task automatic do_txn(input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic er);
    int t0;
    @(posedge clk);
    #1;
    req = 1; addr = a; we = w; be = b; wdata = d;
    wait_gnt(t0);
    @(posedge clk);
    #1;
    req = 0;
    wait_rv(t0, lat, rd, er);
  endtask

  int lat;
  int t0;
  int r;
  logic [31:0] rd;
  logic er;

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1; req = 0; addr = 0; we = 0; be = 0; wdata = 0;
    junk = '0;
    dly[0] = 0; dly[1] = 0;
    tdata[0] = 32'h12345678;
    tdata[1] = 32'hA5A50001;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1;
    repeat (2) @(posedge clk);

    do_txn(32'hF0010004, 0, 4'hF, 0, lat, rd, er);
    chk("rd_lat", lat, 2);
    chk("rd_data", rd, 32'h12345678);
    chk("rd_err", 32'(er), 0);

    dly[0] = 2;
    do_txn(32'hF0010000, 1, 4'hF, 32'hCAFEF00D, lat, rd, er);
    chk("wr_lat", lat, 4);
    chk("wr_rdata", rd, 0);
    chk("wr_pwdata", pwdata, 32'hCAFEF00D);
    chk("wr_pwe", 32'(pwe), 1);

    do_txn(32'hF0000000, 0, 4'hF, 0, lat, rd, er);
    chk("miss_lat", lat, 1);
    chk("miss_data", rd, BAD);
    chk("miss_err", 32'(er), 1);

    dly[0] = 0;
    do_txn(32'hF0020000, 0, 4'hF, 0, lat, rd, er);
    chk("edge_end_tgt1", rd, 32'hA5A50001);
    do_txn(32'hF0018000, 0, 4'hF, 0, lat, rd, er);
    chk("overlap_tgt0", rd, 32'h12345678);
    do_txn(32'hF002FFFC, 0, 4'h3, 0, lat, rd, er);
    chk("tgt1_lat", lat, 2);
    do_txn(32'hF0030000, 0, 4'hF, 0, lat, rd, er);
    chk("edge_miss", rd, BAD);
    do_txn(32'hF000FFFF, 0, 4'hF, 0, lat, rd, er);
    chk("below_miss_lat", lat, 1);

    @(posedge clk); #1 junk = 2'b11;
    repeat (3) @(posedge clk);
    #1 junk = 2'b00;

    dly[0] = 4;
    junk = 2'b10;
    do_txn(32'hF0010008, 0, 4'hF, 0, lat, rd, er);
    junk = 2'b00;
    chk("other_rdy_lat", lat, 6);

    dly[0] = 5;
    @(posedge clk);
    #1;
    req = 1; addr = 32'hF0010010; we = 0; be = 4'hF;
    wait_gnt(t0);
    @(posedge clk);
    #1 addr = 32'hF0020004;
    wait_rv(t0, lat, rd, er);
    chk("b2b_lat", lat, 7);
    @(negedge clk);
    chk("b2b_regrant", 32'(gnt), 1);
    t0 = cyc;
    @(posedge clk);
    #1 req = 0;
    wait_rv(t0, lat, rd, er);
    chk("b2b_second", rd, 32'hA5A50001);

    dly[0] = 20;
    @(posedge clk);
    #1;
    req = 1; addr = 32'hF0010020;
    wait_gnt(t0);
    @(posedge clk);
    #1 req = 0;
    @(posedge clk);
    #3;
    chk("pre_rst_preq", 32'(preq), 1);
    rst_n = 0;
    #1;
    chk("rst_async_preq", 32'(preq), 0);
    chk("rst_async_rvalid", 32'(rvalid), 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1;
    repeat (4) @(negedge clk);
    dly[0] = 0;
    do_txn(32'hF0010004, 0, 4'hF, 0, lat, rd, er);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", rd, 32'h12345678);

`ifdef CEI_MOCHILA_PERIPH_TIMEOUT_EN
    dly[0] = 1000;
    do_txn(32'hF0010004, 0, 4'hF, 0, lat, rd, er);
    chk("to_lat", lat, 9);
    chk("to_data", rd, BAD);
    chk("to_err", 32'(er), 1);
    @(posedge clk); #1 junk = 2'b01;
    repeat (3) @(posedge clk);
    #1 junk = 2'b00;
    dly[0] = 7;
    do_txn(32'hF0010004, 0, 4'hF, 0, lat, rd, er);
    chk("to_edge_lat", lat, 9);
    chk("to_edge_data", rd, 32'h12345678);
    chk("to_edge_err", 32'(er), 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
